// File: rtl/ps_frame_mux.sv
// Frame-synchronous N-channel stream selector: picks one channel per frame, tags SOF/EOL/EOF,
// buffers pixels in a show-ahead FIFO with a registered output stage, and counts completed frames.
module ps_frame_mux #(
    parameter int DATA_WIDTH = 12,
    parameter int N_CH       = 4,
    parameter int SEL_WIDTH  = 2,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_PTR   = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic [SEL_WIDTH-1:0]       i_sel,
    input  logic                       i_resync,
    input  logic [N_CH*DATA_WIDTH-1:0] i_data,
    input  logic [N_CH-1:0]            i_valid,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [DATA_WIDTH-1:0]      o_data,
    output logic                       o_sof,
    output logic                       o_eol,
    output logic                       o_eof,
    output logic [SEL_WIDTH-1:0]       o_cur_sel,
    output logic [15:0]                o_frame_cnt,
    output logic                       o_overflow
);

    localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int DEPTH = 1 << FIFO_PTR;
    localparam logic [XW-1:0]       X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]       Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [FIFO_PTR:0]   CNT_FULL = {1'b1, {FIFO_PTR{1'b0}}};

    typedef struct packed {
        logic                  sof;
        logic                  eol;
        logic                  eof;
        logic [DATA_WIDTH-1:0] data;
    } pix_t;

    logic [SEL_WIDTH-1:0] sel_meta_q, sel_s_q;
    logic [SEL_WIDTH-1:0] cur_sel_q, cur_sel_d;
    logic [XW-1:0]        x_q, x_d, px_x;
    logic [YW-1:0]        y_q, y_d, px_y;
    logic                 in_vld_q, in_vld_d;
    pix_t                 in_pix_q, in_pix_d;
    logic [FIFO_PTR-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_PTR:0]    cnt_q, cnt_d;
    logic                 out_vld_q, out_vld_d;
    pix_t                 out_pix_q, out_pix_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 ovf_q, ovf_d;
    pix_t                 mem [DEPTH];

    logic                  frame_idle, sel_ok, ch_valid;
    logic [SEL_WIDTH-1:0]  eff_sel;
    logic [DATA_WIDTH-1:0] ch_data;
    logic                  out_load, fifo_empty, fifo_full, fifo_rd, fifo_wr, bypass, wr_req, drop;

    // Selection, geometry and input capture. In the idle cycle between frames the newly
    // requested channel already supplies the first pixel, so a frame is never split.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        frame_idle = (x_q == '0) && (y_q == '0);
        sel_ok     = int'(sel_s_q) < N_CH;
        eff_sel    = (frame_idle && sel_ok) ? sel_s_q : cur_sel_q;
        ch_valid   = 1'b0;
        ch_data    = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (int'(eff_sel) == k) begin
                ch_valid = i_valid[k];
                ch_data  = i_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        px_x      = i_resync ? '0 : x_q;
        px_y      = i_resync ? '0 : y_q;
        cur_sel_d = eff_sel;
        x_d       = px_x;
        y_d       = px_y;
        in_vld_d  = ch_valid;
        in_pix_d  = in_pix_q;
        if (ch_valid) begin
            in_pix_d.sof  = (px_x == '0) && (px_y == '0);
            in_pix_d.eol  = (px_x == X_LAST);
            in_pix_d.eof  = (px_x == X_LAST) && (px_y == Y_LAST);
            in_pix_d.data = ch_data;
            if (px_x == X_LAST) begin
                x_d = '0;
                y_d = (px_y == Y_LAST) ? '0 : px_y + YW'(1);
            end else begin
                x_d = px_x + XW'(1);
            end
        end
    end

    // FIFO and output stage; an empty FIFO lets the input register feed the output directly.
    always_comb begin
        out_load    = !out_vld_q || i_ready;
        fifo_empty  = (cnt_q == '0);
        fifo_full   = (cnt_q == CNT_FULL);
        fifo_rd     = out_load && !fifo_empty;
        bypass      = out_load && fifo_empty && in_vld_q;
        wr_req      = in_vld_q && !bypass;
        fifo_wr     = wr_req && (!fifo_full || fifo_rd);
        drop        = wr_req && !fifo_wr;
        out_vld_d   = out_vld_q;
        out_pix_d   = out_pix_q;
        if (out_load) begin
            out_vld_d = fifo_rd || bypass;
            if (fifo_rd)     out_pix_d = mem[rd_ptr_q];
            else if (bypass) out_pix_d = in_pix_q;
        end
        wr_ptr_d = fifo_wr ? wr_ptr_q + FIFO_PTR'(1) : wr_ptr_q;
        rd_ptr_d = fifo_rd ? rd_ptr_q + FIFO_PTR'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({fifo_wr, fifo_rd})
            2'b10:   cnt_d = cnt_q + (FIFO_PTR+1)'(1);
            2'b01:   cnt_d = cnt_q - (FIFO_PTR+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        frame_cnt_d = (in_vld_q && in_pix_q.eof && !drop) ? frame_cnt_q + 16'd1 : frame_cnt_q;
        ovf_d       = ovf_q || drop;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sel_meta_q  <= '0;
            sel_s_q     <= '0;
            cur_sel_q   <= '0;
            x_q         <= '0;
            y_q         <= '0;
            in_vld_q    <= 1'b0;
            in_pix_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            out_vld_q   <= 1'b0;
            out_pix_q   <= '0;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            sel_meta_q  <= i_sel;
            sel_s_q     <= sel_meta_q;
            cur_sel_q   <= cur_sel_d;
            x_q         <= x_d;
            y_q         <= y_d;
            in_vld_q    <= in_vld_d;
            in_pix_q    <= in_pix_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            out_vld_q   <= out_vld_d;
            out_pix_q   <= out_pix_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    // NOTE: storage is not reset; the occupancy count alone decides which entries are valid.
    always_ff @(posedge i_clk) begin
        if (fifo_wr) mem[wr_ptr_q] <= in_pix_q;
    end

    assign o_valid     = out_vld_q;
    assign o_data      = out_pix_q.data;
    assign o_sof       = out_pix_q.sof;
    assign o_eol       = out_pix_q.eol;
    assign o_eof       = out_pix_q.eof;
    assign o_cur_sel   = cur_sel_q;
    assign o_frame_cnt = frame_cnt_q;
    assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_ps_frame_mux.sv
// Self-checking bench for ps_frame_mux: directed scenarios plus random traffic, compared every
// cycle against a transaction-level model (linear frame position, 9-slot output store).
module tb_ps_frame_mux;

    localparam int DW = 12;
    localparam int NC = 4;
    localparam int SW = 3;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int FP = 3;
    localparam int STORE = (1 << FP) + 1;

    typedef struct packed {
        logic          sof;
        logic          eol;
        logic          eof;
        logic [DW-1:0] data;
    } px_t;

    logic             clk = 1'b0;
    logic             i_rstn;
    logic [SW-1:0]    i_sel;
    logic             i_resync;
    logic [NC*DW-1:0] i_data;
    logic [NC-1:0]    i_valid;
    logic             i_ready;
    logic             o_valid, o_sof, o_eol, o_eof, o_overflow;
    logic [DW-1:0]    o_data;
    logic [SW-1:0]    o_cur_sel;
    logic [15:0]      o_frame_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    px_t           exp_q[$];
    px_t           pend;
    bit            pend_v;
    int            pos_m;
    logic [SW-1:0] ch_m, sel_meta_m, sel_s_m;
    logic [15:0]   frames_m;
    logic          ovf_m;

    always #5 clk = ~clk;

    ps_frame_mux #(
        .DATA_WIDTH(DW), .N_CH(NC), .SEL_WIDTH(SW),
        .H_ACTIVE(H), .V_ACTIVE(V), .FIFO_PTR(FP)
    ) dut (
        .i_clk(clk), .i_rstn(i_rstn), .i_sel(i_sel), .i_resync(i_resync),
        .i_data(i_data), .i_valid(i_valid), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof),
        .o_cur_sel(o_cur_sel), .o_frame_cnt(o_frame_cnt), .o_overflow(o_overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend_v     = 0;
        pend       = '0;
        pos_m      = 0;
        ch_m       = '0;
        sel_meta_m = '0;
        sel_s_m    = '0;
        frames_m   = '0;
        ovf_m      = 1'b0;
    endtask

    // One clock edge of the reference: output store drains, last cycle's pixel is stored or
    // dropped, then this cycle's pixel is taken from the channel in force.
    task automatic model_edge();
        logic [SW-1:0] eff;
        int p;
        if (exp_q.size() > 0 && i_ready) void'(exp_q.pop_front());
        if (pend_v) begin
            if (exp_q.size() < STORE) begin
                exp_q.push_back(pend);
                if (pend.eof) frames_m = frames_m + 16'd1;
            end else begin
                ovf_m = 1'b1;
            end
        end
        eff  = (pos_m == 0 && int'(sel_s_m) < NC) ? sel_s_m : ch_m;
        ch_m = eff;
        p    = i_resync ? 0 : pos_m;
        if (i_valid[int'(eff)]) begin
            pend.data = i_data[int'(eff)*DW +: DW];
            pend.sof  = (p == 0);
            pend.eol  = (p % H) == H - 1;
            pend.eof  = (p == H*V - 1);
            pend_v    = 1;
            pos_m     = (p + 1) % (H*V);
        end else begin
            pend_v = 0;
            pos_m  = p;
        end
        sel_s_m    = sel_meta_m;
        sel_meta_m = i_sel;
    endtask

    task automatic compare();
        if (exp_q.size() > 0)
            check("out", {o_valid, o_sof, o_eol, o_eof, o_data},
                  {1'b1, exp_q[0].sof, exp_q[0].eol, exp_q[0].eof, exp_q[0].data});
        else
            check("out_vld", o_valid, 1'b0);
        check("frame_cnt", o_frame_cnt, frames_m);
        check("ovf_sel", {o_overflow, o_cur_sel}, {ovf_m, ch_m});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic rand_data();
        for (int k = 0; k < NC; k++) i_data[k*DW +: DW] = DW'($urandom);
    endtask

    task automatic idle(input int n);
        i_valid = '0;
        for (int i = 0; i < n; i++) begin
            rand_data();
            cycle();
        end
    endtask

    task automatic stream(input int n, input logic [NC-1:0] vmask);
        for (int i = 0; i < n; i++) begin
            rand_data();
            i_valid = vmask;
            cycle();
        end
        i_valid = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {o_valid, o_sof, o_eol, o_eof, o_data, o_cur_sel, o_frame_cnt, o_overflow}, 64'd0);
    endtask

    initial begin
        int n;
        i_rstn = 1'b0; i_sel = '0; i_resync = 1'b0; i_valid = '0; i_ready = 1'b1; i_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        i_rstn = 1'b1;
        idle(3);

        // 1) one frame from ch0, counting pixels 1..8
        for (int p = 0; p < 8; p++) begin
            rand_data();
            i_data[0 +: DW] = DW'(p + 1);
            i_valid = 4'b0001;
            cycle();
            if (p == 0) check("latency_1", o_valid, 1'b0);
            if (p == 1) check("latency_2", o_valid, 1'b1);
        end
        idle(4);
        check("t1_frames", o_frame_cnt, 16'd1);

        // 2) selection request arrives mid-frame; switch happens only at the frame boundary
        for (int p = 0; p < 16; p++) begin
            if (p == 3) i_sel = 3'd2;
            rand_data();
            i_valid = 4'b0101;
            cycle();
        end
        idle(4);
        check("t2_cur_sel", o_cur_sel, 3'd2);
        check("t2_frames", o_frame_cnt, 16'd3);

        // 3) downstream stalled for 12 accepted pixels: 9 kept, 3 dropped
        i_ready = 1'b0;
        stream(12, 4'b0100);
        idle(3);
        check("t3_overflow", o_overflow, 1'b1);
        check("t3_frames", o_frame_cnt, 16'd4);
        i_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            if (o_valid) n++;
            rand_data();
            cycle();
        end
        check("t3_drained", 64'(n), 64'd9);

        // 4) realign, then resync coincident with the 5th pixel of a frame
        i_resync = 1'b1;
        idle(1);
        i_resync = 1'b0;
        for (int p = 0; p < 12; p++) begin
            i_resync = (p == 4);
            rand_data();
            i_valid = 4'b0100;
            cycle();
        end
        i_resync = 1'b0;
        idle(4);
        check("t4_frames", o_frame_cnt, 16'd5);

        // 5) out-of-range selection is ignored; reset mid-frame
        i_sel = 3'd7;
        idle(6);
        check("t5_sel_held", o_cur_sel, 3'd2);
        stream(3, 4'b0101);
        i_sel = 3'd0;
        i_rstn = 1'b0;
        #1;
        check_reset_outputs("reset_mid_frame");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        i_rstn = 1'b1;
        stream(8, 4'b0101);
        idle(4);
        check("t5_frames", o_frame_cnt, 16'd1);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 39) == 0) i_sel = SW'($urandom_range(0, 7));
            i_resync = ($urandom_range(0, 49) == 0);
            for (int k = 0; k < NC; k++) i_valid[k] = ($urandom_range(0, 3) != 0);
            i_ready = (c >= 200 && c < 230) ? 1'b0 : ($urandom_range(0, 3) != 0);
            rand_data();
            cycle();
        end
        i_resync = 1'b0;
        i_ready  = 1'b1;
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
